csr_trap_sequencer: RTL and testbench
=====================================

// Module: csr_trap_sequencer
// PURPOSE
//  Owns the single CSR-file write port. Arbitrates between EXE-stage CSR instruction writes
//  and a multi-cycle trap sequencer that saves mepc/mstatus/mcause on interrupt, ecall or ebreak.
//  Restores mstatus on mret. Stalls the pipeline and redirects the PC while a sequence runs.
//  Sits between exe and csr_reg; hold_out drives pipeline stall, jump_* drives the pc stage.
// PARAMETERS
//  DW        32            data/CSR width
//  AW        12            CSR address width
//  IRQ_CAUSE 32'h8000_000B mcause value written for an external interrupt
// PORTS
//  clk_in          in   1   clock
//  rst_n_in        in   1   asynchronous reset, active low
//  inst_in         in   DW  instruction in EXE
//  pc_in           in   DW  PC of inst_in
//  exe_csr_we_in   in   1   EXE requests CSR write
//  exe_csr_waddr_in in  AW  EXE CSR write address
//  exe_csr_wdata_in in  DW  EXE CSR write data
//  irq_in          in   1   external interrupt request, level
//  mstatus_in      in   DW  current mstatus from csr_reg
//  mtvec_in        in   DW  current mtvec
//  mepc_in         in   DW  current mepc
//  csr_we_out      out  1   CSR-file write enable
//  csr_waddr_out   out  AW  CSR-file write address
//  csr_wdata_out   out  DW  CSR-file write data
//  hold_out        out  1   pipeline stall, high while state != IDLE
//  jump_out        out  1   one-cycle PC redirect
//  jump_addr_out   out  DW  redirect target
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, cause_q=0, pc_q=0. Reset mid-sequence aborts with no further writes.
//  Decode: ecall=32'h0000_0073, ebreak=32'h0010_0073, mret=32'h3020_0073.
//  Interrupt taken only when irq_in && mstatus_in[3] (MIE).
//  IDLE, registered next-state decision, priority: irq > ecall/ebreak > mret > EXE write.
//   irq:   pc_q=pc_in, cause_q=IRQ_CAUSE -> S_MEPC. The EXE write of that cycle is dropped;
//          the instruction re-executes after mret.
//   ecall: pc_q=pc_in, cause_q=11 -> S_MEPC.
//   ebreak: pc_q=pc_in, cause_q=3 -> S_MEPC.
//   mret:  -> S_MRET.
//   else:  csr_we/waddr/wdata_out pass EXE signals combinationally, zero latency.
//  S_MEPC:    write 0x341 <= pc_q -> S_MSTATUS.
//  S_MSTATUS: write 0x300 <= mstatus_in with MPIE[7]=MIE[3], MIE=0 -> S_MCAUSE.
//  S_MCAUSE:  write 0x342 <= cause_q -> S_JUMP.
//  S_JUMP:    jump_out=1, jump_addr_out={mtvec_in[DW-1:2],2'b00} -> IDLE.
//  S_MRET:    write 0x300 <= mstatus_in with MIE=MPIE, MPIE=1 -> S_RET.
//  S_RET:     jump_out=1, jump_addr_out=mepc_in -> IDLE.
//  Outside IDLE: EXE writes are ignored and hold_out=1. irq_in is not re-sampled until IDLE.
//  Because MIE is cleared in S_MSTATUS, no nested trap occurs.
//  Latency: trap = 4 cycles after decision (3 writes + jump); mret = 2 cycles.
//  Exactly one CSR write per cycle. csr_we_out=0 in S_JUMP/S_RET and when idle with no request.
// CONFIGURATION
//  CSR_TRAP_VECTORED_EN defined: if mtvec_in[1:0]==2'b01 and cause_q[DW-1]==1, the S_JUMP target is
//   {mtvec_in[DW-1:2],2'b00} + 4*cause_q[DW-2:0]. Exceptions still go to the base address.
//  Undefined: always direct mode, target base; mtvec_in[1:0] is ignored.
// STRUCTURE
//  Shared package/defines: CSR addresses (MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342),
//   cause codes, ecall/ebreak/mret encodings, state encoding localparams.
//  One sub-module is natural: csr_wport_mux, a combinational select of the EXE path vs the FSM path onto the write port.
// TESTING
//  1 irq_in=1, MIE=1, pc_in=0x100, mtvec=0x200 -> writes mepc=0x100, mstatus MIE 1->0/MPIE=1,
//    mcause=0x8000000B on consecutive cycles; then jump to 0x200; hold high 4 cycles.
//  2 irq_in=1 with MIE=0 and EXE write 0x305<=0x400 -> passthrough write, no trap, hold=0.
//  3 ecall at pc 0x40 with EXE write same cycle -> EXE write suppressed; mcause=11, mepc=0x40, jump to mtvec.
//  4 mret with mstatus=0x80, mepc=0x104 -> write mstatus=0x88, then jump 0x104.
//  5 rst_n_in low during S_MSTATUS -> outputs 0 asynchronously; no mcause write after release; state IDLE.
//  6 CSR_TRAP_VECTORED_EN defined, mtvec=0x201, irq with cause 11 -> jump 0x22C; undefined build -> 0x200.

Source files
------------

// File: rtl/csr_trap_sequencer_pkg.sv
// Shared constants for the CSR trap sequencer: CSR addresses, cause codes,
// SYSTEM instruction encodings and the sequencer state encoding.
package csr_trap_sequencer_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;
    localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MEPC    = 3'd1,
        S_MSTATUS = 3'd2,
        S_MCAUSE  = 3'd3,
        S_JUMP    = 3'd4,
        S_MRET    = 3'd5,
        S_RET     = 3'd6
    } trap_state_e;

endpackage

// File: rtl/csr_trap_sequencer_wport.sv
// Combinational select of the single CSR-file write port between the EXE
// path and the trap sequencer path; an idle port drives zero address/data.
module csr_trap_sequencer_wport #(
    parameter int DW = 32,
    parameter int AW = 12
) (
    input  logic          exe_sel,
    input  logic          exe_we,
    input  logic [AW-1:0] exe_waddr,
    input  logic [DW-1:0] exe_wdata,
    input  logic          fsm_we,
    input  logic [AW-1:0] fsm_waddr,
    input  logic [DW-1:0] fsm_wdata,
    output logic          csr_we,
    output logic [AW-1:0] csr_waddr,
    output logic [DW-1:0] csr_wdata
);

    always_comb begin
        csr_we    = 1'b0;
        csr_waddr = '0;
        csr_wdata = '0;
        if (fsm_we) begin
            csr_we    = 1'b1;
            csr_waddr = fsm_waddr;
            csr_wdata = fsm_wdata;
        end else if (exe_sel && exe_we) begin
            csr_we    = 1'b1;
            csr_waddr = exe_waddr;
            csr_wdata = exe_wdata;
        end
    end

endmodule

// File: rtl/csr_trap_sequencer.sv
// CSR write-port owner: passes EXE CSR writes through, or runs the trap / mret
// sequence with pipeline hold and PC redirect. Optional: CSR_TRAP_VECTORED_EN.
//
// state     | meaning
// S_IDLE    | EXE writes pass through; trap/mret decision registered here
// S_MEPC    | write mepc <= trapping pc
// S_MSTATUS | write mstatus with MPIE<=MIE, MIE<=0
// S_MCAUSE  | write mcause <= cause
// S_JUMP    | redirect PC to trap vector
// S_MRET    | write mstatus with MIE<=MPIE, MPIE<=1
// S_RET     | redirect PC to mepc
module csr_trap_sequencer
    import csr_trap_sequencer_pkg::*;
#(
    parameter int            DW        = 32,
    parameter int            AW        = 12,
    parameter logic [DW-1:0] IRQ_CAUSE = DW'(32'h8000_000B)
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic [DW-1:0] inst_in,
    input  logic [DW-1:0] pc_in,
    input  logic          exe_csr_we_in,
    input  logic [AW-1:0] exe_csr_waddr_in,
    input  logic [DW-1:0] exe_csr_wdata_in,
    input  logic          irq_in,
    input  logic [DW-1:0] mstatus_in,
    input  logic [DW-1:0] mtvec_in,
    input  logic [DW-1:0] mepc_in,
    output logic          csr_we_out,
    output logic [AW-1:0] csr_waddr_out,
    output logic [DW-1:0] csr_wdata_out,
    output logic          hold_out,
    output logic          jump_out,
    output logic [DW-1:0] jump_addr_out
);

    trap_state_e   state_q, state_d;
    logic [DW-1:0] pc_q, pc_d;
    logic [DW-1:0] cause_q, cause_d;

    logic          fsm_we;
    logic [AW-1:0] fsm_waddr;
    logic [DW-1:0] fsm_wdata;
    logic          exe_sel;
    logic          exe_we_gated;
    logic          irq_take;
    logic          is_ecall, is_ebreak, is_mret;
    logic [DW-1:0] trap_base, trap_target;

    assign irq_take  = irq_in && mstatus_in[MSTATUS_MIE];
    assign is_ecall  = (inst_in == DW'(INST_ECALL));
    assign is_ebreak = (inst_in == DW'(INST_EBREAK));
    assign is_mret   = (inst_in == DW'(INST_MRET));

    // Keeps the write port quiet while reset is held, even if EXE is requesting.
    assign exe_we_gated = exe_csr_we_in && rst_n_in;

    assign trap_base = {mtvec_in[DW-1:2], 2'b00};

`ifdef CSR_TRAP_VECTORED_EN
    // Vectored mode only applies to interrupts; exceptions land on the base.
    assign trap_target = (mtvec_in[1:0] == 2'b01 && cause_q[DW-1])
                       ? trap_base + {cause_q[DW-3:0], 2'b00}
                       : trap_base;
`else
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^mtvec_in[1:0];
    assign trap_target       = trap_base;
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        cause_d       = cause_q;
        fsm_we        = 1'b0;
        fsm_waddr     = '0;
        fsm_wdata     = '0;
        exe_sel       = 1'b0;
        jump_out      = 1'b0;
        jump_addr_out = '0;
        case (state_q)
            S_IDLE: begin
                if (irq_take) begin
                    pc_d    = pc_in;
                    cause_d = IRQ_CAUSE;
                    state_d = S_MEPC;
                end else if (is_ecall) begin
                    pc_d    = pc_in;
                    cause_d = DW'(CAUSE_ECALL_M);
                    state_d = S_MEPC;
                end else if (is_ebreak) begin
                    pc_d    = pc_in;
                    cause_d = DW'(CAUSE_BREAKPOINT);
                    state_d = S_MEPC;
                end else if (is_mret) begin
                    state_d = S_MRET;
                end else begin
                    exe_sel = 1'b1;
                end
            end
            S_MEPC: begin
                fsm_we    = 1'b1;
                fsm_waddr = AW'(CSR_MEPC);
                fsm_wdata = pc_q;
                state_d   = S_MSTATUS;
            end
            S_MSTATUS: begin
                fsm_we                  = 1'b1;
                fsm_waddr               = AW'(CSR_MSTATUS);
                fsm_wdata               = mstatus_in;
                fsm_wdata[MSTATUS_MPIE] = mstatus_in[MSTATUS_MIE];
                fsm_wdata[MSTATUS_MIE]  = 1'b0;
                state_d                 = S_MCAUSE;
            end
            S_MCAUSE: begin
                fsm_we    = 1'b1;
                fsm_waddr = AW'(CSR_MCAUSE);
                fsm_wdata = cause_q;
                state_d   = S_JUMP;
            end
            S_JUMP: begin
                jump_out      = 1'b1;
                jump_addr_out = trap_target;
                state_d       = S_IDLE;
            end
            S_MRET: begin
                fsm_we                  = 1'b1;
                fsm_waddr               = AW'(CSR_MSTATUS);
                fsm_wdata               = mstatus_in;
                fsm_wdata[MSTATUS_MIE]  = mstatus_in[MSTATUS_MPIE];
                fsm_wdata[MSTATUS_MPIE] = 1'b1;
                state_d                 = S_RET;
            end
            S_RET: begin
                jump_out      = 1'b1;
                jump_addr_out = mepc_in;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign hold_out = (state_q != S_IDLE);

    csr_trap_sequencer_wport #(
        .DW(DW),
        .AW(AW)
    ) u_wport (
        .exe_sel   (exe_sel),
        .exe_we    (exe_we_gated),
        .exe_waddr (exe_csr_waddr_in),
        .exe_wdata (exe_csr_wdata_in),
        .fsm_we    (fsm_we),
        .fsm_waddr (fsm_waddr),
        .fsm_wdata (fsm_wdata),
        .csr_we    (csr_we_out),
        .csr_waddr (csr_waddr_out),
        .csr_wdata (csr_wdata_out)
    );

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Directed bench for csr_trap_sequencer: per-cycle vector table plus a
// hand-written reset-abort sequence. Honours CSR_TRAP_VECTORED_EN.
module tb_csr_trap_sequencer;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
`ifdef CSR_TRAP_VECTORED_EN
    localparam logic [31:0] IRQ_VEC_TARGET = 32'h0000_022C;
`else
    localparam logic [31:0] IRQ_VEC_TARGET = 32'h0000_0200;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst = '0, pc = '0;
    logic        exe_we = 1'b0;
    logic [11:0] exe_waddr = '0;
    logic [31:0] exe_wdata = '0;
    logic        irq = 1'b0;
    logic [31:0] mstatus = '0, mtvec = '0, mepc = '0;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        hold, jump;
    logic [31:0] jump_addr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    csr_trap_sequencer dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .inst_in          (inst),
        .pc_in            (pc),
        .exe_csr_we_in    (exe_we),
        .exe_csr_waddr_in (exe_waddr),
        .exe_csr_wdata_in (exe_wdata),
        .irq_in           (irq),
        .mstatus_in       (mstatus),
        .mtvec_in         (mtvec),
        .mepc_in          (mepc),
        .csr_we_out       (csr_we),
        .csr_waddr_out    (csr_waddr),
        .csr_wdata_out    (csr_wdata),
        .hold_out         (hold),
        .jump_out         (jump),
        .jump_addr_out    (jump_addr)
    );

    typedef struct {
        logic        irq;
        logic [31:0] inst, pc;
        logic        we;
        logic [11:0] waddr;
        logic [31:0] wdata, mstatus, mtvec, mepc;
        logic        e_we;
        logic [11:0] e_waddr;
        logic [31:0] e_wdata;
        logic        e_hold, e_jump;
        logic [31:0] e_jaddr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic i_irq, logic [31:0] i_inst, logic [31:0] i_pc,
                                logic i_we, logic [11:0] i_wa, logic [31:0] i_wd,
                                logic [31:0] i_ms, logic [31:0] i_tv, logic [31:0] i_ep,
                                logic x_we, logic [11:0] x_wa, logic [31:0] x_wd,
                                logic x_hold, logic x_jump, logic [31:0] x_ja);
        vec_t v;
        v.irq = i_irq; v.inst = i_inst; v.pc = i_pc;
        v.we = i_we; v.waddr = i_wa; v.wdata = i_wd;
        v.mstatus = i_ms; v.mtvec = i_tv; v.mepc = i_ep;
        v.e_we = x_we; v.e_waddr = x_wa; v.e_wdata = x_wd;
        v.e_hold = x_hold; v.e_jump = x_jump; v.e_jaddr = x_ja;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic apply(vec_t v);
        irq = v.irq; inst = v.inst; pc = v.pc;
        exe_we = v.we; exe_waddr = v.waddr; exe_wdata = v.wdata;
        mstatus = v.mstatus; mtvec = v.mtvec; mepc = v.mepc;
    endtask

    initial begin
        // irq trap, pc 0x100
        tbl.push_back(mk(1, NOP, 'h100, 1, 'h305, 'h123, 'h8, 'h200, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, NOP, 'h100, 0, 0, 0, 'h8, 'h200, 0,  1, 'h341, 'h100, 1, 0, 0));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 'h8, 'h200, 0,  1, 'h300, 'h80, 1, 0, 0));
        tbl.push_back(mk(0, NOP, 0, 1, 'h305, 'h555, 'h80, 'h200, 0,  1, 'h342, 'h8000_000B, 1, 0, 0));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 'h80, 'h200, 0,  0, 0, 0, 1, 1, 'h200));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 'h8, 'h200, 0,  0, 0, 0, 0, 0, 0));
        // irq masked: passthrough
        tbl.push_back(mk(1, NOP, 0, 1, 'h305, 'h400, 'h0, 'h200, 0,  1, 'h305, 'h400, 0, 0, 0));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 'h0, 'h200, 0,  0, 0, 0, 0, 0, 0));
        // ecall at 0x40 with same-cycle EXE write
        tbl.push_back(mk(0, ECALL, 'h40, 1, 'h305, 'h999, 'h8, 'h200, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 'h8, 'h200, 0,  1, 'h341, 'h40, 1, 0, 0));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 'h8, 'h200, 0,  1, 'h300, 'h80, 1, 0, 0));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 'h8, 'h200, 0,  1, 'h342, 'd11, 1, 0, 0));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 'h8, 'h200, 0,  0, 0, 0, 1, 1, 'h200));
        // mret
        tbl.push_back(mk(0, MRET, 0, 0, 0, 0, 'h80, 'h200, 'h104,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 'h80, 'h200, 'h104,  1, 'h300, 'h88, 1, 0, 0));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 'h80, 'h200, 'h104,  0, 0, 0, 1, 1, 'h104));
        // ebreak, mtvec mode bits set: exceptions still go to base
        tbl.push_back(mk(0, EBREAK, 'h60, 0, 0, 0, 'h88, 'h201, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 'h88, 'h201, 0,  1, 'h341, 'h60, 1, 0, 0));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 'h88, 'h201, 0,  1, 'h300, 'h80, 1, 0, 0));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 'h88, 'h201, 0,  1, 'h342, 'd3, 1, 0, 0));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 'h88, 'h201, 0,  0, 0, 0, 1, 1, 'h200));
        // irq beats ecall; vectored target when enabled
        tbl.push_back(mk(1, ECALL, 'h70, 0, 0, 0, 'h8, 'h201, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 'h8, 'h201, 0,  1, 'h341, 'h70, 1, 0, 0));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 'h8, 'h201, 0,  1, 'h300, 'h80, 1, 0, 0));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 'h8, 'h201, 0,  1, 'h342, 'h8000_000B, 1, 0, 0));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 'h8, 'h201, 0,  0, 0, 0, 1, 1, IRQ_VEC_TARGET));
        tbl.push_back(mk(0, NOP, 0, 1, 'h300, 'h1, 'h8, 'h200, 0,  1, 'h300, 'h1, 0, 0, 0));

        #3;
        chk("rst_we", {31'd0, csr_we}, 0);
        chk("rst_hold", {31'd0, hold}, 0);
        chk("rst_jump", {31'd0, jump}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            apply(tbl[i]);
            @(negedge clk);
            chk($sformatf("row%0d_we", i), {31'd0, csr_we}, {31'd0, tbl[i].e_we});
            chk($sformatf("row%0d_hold", i), {31'd0, hold}, {31'd0, tbl[i].e_hold});
            chk($sformatf("row%0d_jump", i), {31'd0, jump}, {31'd0, tbl[i].e_jump});
            if (tbl[i].e_we) begin
                chk($sformatf("row%0d_waddr", i), {20'd0, csr_waddr}, {20'd0, tbl[i].e_waddr});
                chk($sformatf("row%0d_wdata", i), csr_wdata, tbl[i].e_wdata);
            end
            if (tbl[i].e_jump)
                chk($sformatf("row%0d_jaddr", i), jump_addr, tbl[i].e_jaddr);
        end

        // reset asserted during S_MSTATUS aborts the sequence
        @(posedge clk); #1;
        irq = 1; inst = NOP; pc = 'h100; mstatus = 'h8; mtvec = 'h200; exe_we = 0;
        @(negedge clk);
        chk("rs_idle_we", {31'd0, csr_we}, 0);
        @(posedge clk); #1;
        irq = 0;
        @(negedge clk);
        chk("rs_mepc_addr", {20'd0, csr_waddr}, 'h341);
        @(posedge clk); #1;
        chk("rs_mstatus_addr", {20'd0, csr_waddr}, 'h300);
        chk("rs_mstatus_hold", {31'd0, hold}, 1);
        #2;
        exe_we = 1; exe_waddr = 'h305; exe_wdata = 'h777;
        rst_n = 0;
        #1;
        chk("rs_async_we", {31'd0, csr_we}, 0);
        chk("rs_async_hold", {31'd0, hold}, 0);
        chk("rs_async_jump", {31'd0, jump}, 0);
        @(negedge clk);
        exe_we = 0;
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("rs_post%0d_we", k), {31'd0, csr_we}, 0);
            chk($sformatf("rs_post%0d_hold", k), {31'd0, hold}, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
